// File: rtl/bullet_pool_ctrl_if.sv
// Signal bundle between the game logic and the bullet pool controller.
// The master drives fire/hit requests; the slave (the pool) reports slot state.
interface bullet_pool_ctrl_if #(
  parameter int NUM_SLOTS = 4
);
  localparam int IDX_W = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;

  logic                     update_tick;
  logic                     shoot;
  logic [9:0]               kid_x;
  logic [9:0]               kid_y;
  logic                     kid_dir;
  logic                     hit_valid;
  logic [IDX_W-1:0]         hit_idx;
  logic [NUM_SLOTS-1:0]     slot_valid;
  logic [11*NUM_SLOTS-1:0]  slot_x;
  logic [10*NUM_SLOTS-1:0]  slot_y;
  logic                     fire_ack;
  logic                     fire_drop;
  logic                     pool_full;

  modport master (
    output update_tick, shoot, kid_x, kid_y, kid_dir, hit_valid, hit_idx,
    input  slot_valid, slot_x, slot_y, fire_ack, fire_drop, pool_full
  );

  modport slave (
    input  update_tick, shoot, kid_x, kid_y, kid_dir, hit_valid, hit_idx,
    output slot_valid, slot_x, slot_y, fire_ack, fire_drop, pool_full
  );
endinterface

// File: rtl/bullet_pool_ctrl.sv
// Fixed pool of horizontally moving bullets: debounced fire requests with a
// cooldown, per-frame motion, off-screen retirement and collision clears.
module bullet_pool_ctrl #(
  parameter int NUM_SLOTS = 4,
  parameter int SCREEN_W  = 800,
  parameter int BULLET_W  = 4,
  parameter int SPEED     = 4,
  parameter int COOLDOWN  = 8
) (
  input  logic               clk,
  input  logic               rst,
  bullet_pool_ctrl_if.slave  bus
);
  localparam int IDX_W = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;
  localparam int CD_W  = (COOLDOWN > 0) ? $clog2(COOLDOWN + 1) : 1;

  localparam logic signed [10:0] X_RESET = 11'(SCREEN_W + 1);
  localparam logic signed [10:0] X_MAX   = 11'(SCREEN_W);
  localparam logic signed [10:0] X_MIN   = 11'(-BULLET_W);
  localparam logic signed [10:0] STEP    = 11'(SPEED);
  localparam logic [CD_W-1:0]    CD_LOAD = CD_W'(COOLDOWN);

  logic [NUM_SLOTS-1:0] valid_q;
  logic [NUM_SLOTS-1:0] dir_q;
  logic signed [10:0]   x_q [NUM_SLOTS];
  logic [9:0]           y_q [NUM_SLOTS];
  logic                 shoot_q;
  logic                 pending_q;
  logic [CD_W-1:0]      cooldown_q;
  logic                 fire_ack_q;
  logic                 fire_drop_q;

  logic                 shoot_rise;
  logic [NUM_SLOTS-1:0] hit_vec;
  logic [NUM_SLOTS-1:0] keep_vec;
  logic signed [10:0]   moved_x [NUM_SLOTS];
  logic                 any_free;
  logic                 hit_any;
  logic                 service;
  logic                 do_spawn;
  logic                 do_drop;
  logic [IDX_W-1:0]     spawn_idx;

  assign shoot_rise = bus.shoot & ~shoot_q;
  assign any_free   = ~(&valid_q);
  assign hit_any    = |hit_vec;
  assign service    = bus.update_tick & pending_q & (cooldown_q == '0);
  assign do_spawn   = service & any_free;
  // A full pool that is losing a slot to a hit this cycle keeps the request
  // pending so it lands in the freed slot on the next tick instead of dropping.
  assign do_drop    = service & ~any_free & ~hit_any;

  always_comb begin
    hit_vec  = '0;
    keep_vec = '0;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      hit_vec[i]  = bus.hit_valid && (bus.hit_idx == IDX_W'(i)) && valid_q[i];
      moved_x[i]  = dir_q[i] ? (x_q[i] + STEP) : (x_q[i] - STEP);
      keep_vec[i] = (moved_x[i] < X_MAX) && (moved_x[i] >= X_MIN);
    end
  end

  always_comb begin
    spawn_idx = '0;
    for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
      if (!valid_q[i]) spawn_idx = IDX_W'(i);
    end
  end

  // Per-slot priority: hit clears, then spawn into a free slot, then motion.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= '0;
      dir_q   <= '1;
      for (int i = 0; i < NUM_SLOTS; i++) begin
        x_q[i] <= X_RESET;
        y_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_SLOTS; i++) begin
        if (hit_vec[i]) begin
          valid_q[i] <= 1'b0;
        end else if (do_spawn && (spawn_idx == IDX_W'(i))) begin
          valid_q[i] <= 1'b1;
          x_q[i]     <= {1'b0, bus.kid_x};
          y_q[i]     <= bus.kid_y;
          dir_q[i]   <= bus.kid_dir;
        end else if (bus.update_tick && valid_q[i]) begin
          x_q[i]     <= moved_x[i];
          valid_q[i] <= keep_vec[i];
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shoot_q     <= 1'b0;
      pending_q   <= 1'b0;
      cooldown_q  <= '0;
      fire_ack_q  <= 1'b0;
      fire_drop_q <= 1'b0;
    end else begin
      shoot_q     <= bus.shoot;
      pending_q   <= (pending_q & ~(do_spawn | do_drop)) | (shoot_rise & ~pending_q);
      fire_ack_q  <= do_spawn;
      fire_drop_q <= do_drop;
      if (do_spawn) begin
        cooldown_q <= CD_LOAD;
      end else if (bus.update_tick && (cooldown_q != '0)) begin
        cooldown_q <= cooldown_q - 1'b1;
      end
    end
  end

  assign bus.slot_valid = valid_q;
  assign bus.fire_ack   = fire_ack_q;
  assign bus.fire_drop  = fire_drop_q;
  assign bus.pool_full  = &valid_q;

  for (genvar g = 0; g < NUM_SLOTS; g++) begin : g_pack
    assign bus.slot_x[11*g +: 11] = x_q[g];
    assign bus.slot_y[10*g +: 10] = y_q[g];
  end
endmodule
